// File: rtl/branch_resolve_buffer.sv
// In-order branch resolution buffer: allocates per dispatched branch, captures the
// out-of-order execute outcome by tag, and releases entries in program order at retire.
module branch_resolve_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned TAG_W = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic [WAYS-1:0]              disp_valid_i,
    input  logic [WAYS*TAG_W-1:0]        disp_tag_i,
    input  logic [WAYS-1:0]              disp_pred_taken_i,
    input  logic [WAYS*XLEN-1:0]         disp_pred_target_i,
    output logic                         disp_ready_o,
    input  logic                         res_valid_i,
    input  logic [TAG_W-1:0]             res_tag_i,
    input  logic                         res_taken_i,
    input  logic [XLEN-1:0]              res_target_i,
    input  logic [XLEN-1:0]              res_pc_i,
    input  logic [WAYS-1:0]              ret_en_i,
    output logic [WAYS-1:0]              ret_mispred_o,
    output logic [WAYS*XLEN-1:0]         ret_target_o,
    output logic                         ret_err_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] idx_t;
    typedef logic [PTR_W:0]   ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] resolved_q, resolved_d;
    logic [DEPTH-1:0] pred_taken_q, pred_taken_d;
    logic [DEPTH-1:0] mispred_q, mispred_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [XLEN-1:0]  pred_target_q [DEPTH];
    logic [XLEN-1:0]  pred_target_d [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  target_d [DEPTH];

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;
    logic err_q, err_d;

    logic            res_hit;
    idx_t            res_idx;
    logic            res_mispred;
    logic [XLEN-1:0] res_target;

    // Oldest-first search: walk from head so the first hit is the oldest pending match.
    always_comb begin : resolve_search
        idx_t probe;
        probe   = '0;
        res_hit = 1'b0;
        res_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            probe = head_q[PTR_W-1:0] + idx_t'(i);
            if (!res_hit && res_valid_i && valid_q[probe] && !resolved_q[probe] &&
                tag_q[probe] == res_tag_i) begin
                res_hit = 1'b1;
                res_idx = probe;
            end
        end
    end

    always_comb begin : redirect_rule
        res_mispred = 1'b0;
        res_target  = '0;
        if (res_taken_i) begin
            if (!pred_taken_q[res_idx] || pred_target_q[res_idx] != res_target_i) begin
                res_mispred = 1'b1;
                res_target  = res_target_i;
            end
        end else if (pred_taken_q[res_idx]) begin
            res_mispred = 1'b1;
            res_target  = res_pc_i + XLEN'(32'd4);
        end
    end

    // Readiness looks only at registered occupancy; same-cycle retires do not help.
    assign disp_ready_o = (int'(DEPTH) - int'(count_q)) >= int'(WAYS);

    always_comb begin : next_state
        idx_t slot;
        cnt_t n_ret;
        cnt_t n_disp;

        valid_d       = valid_q;
        resolved_d    = resolved_q;
        pred_taken_d  = pred_taken_q;
        mispred_d     = mispred_q;
        tag_d         = tag_q;
        pred_target_d = pred_target_q;
        target_d      = target_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        err_d         = err_q;
        ret_mispred_o = '0;
        ret_target_o  = '0;
        slot          = '0;
        n_ret         = '0;
        n_disp        = '0;

        if (!flush_i) begin
            if (res_hit) begin
                resolved_d[res_idx] = 1'b1;
                mispred_d[res_idx]  = res_mispred;
                target_d[res_idx]   = res_target;
            end

            for (int k = 0; k < int'(WAYS); k++) begin
                if (ret_en_i[k]) begin
                    slot  = head_q[PTR_W-1:0] + idx_t'(k);
                    n_ret = n_ret + cnt_t'(1);
                    if (res_hit && res_idx == slot) begin
                        ret_mispred_o[k]               = res_mispred;
                        ret_target_o[k*XLEN +: XLEN]   = res_target;
                    end else if (valid_q[slot] && resolved_q[slot]) begin
                        ret_mispred_o[k]               = mispred_q[slot];
                        ret_target_o[k*XLEN +: XLEN]   = target_q[slot];
                    end else begin
                        err_d = 1'b1;
                    end
                    valid_d[slot]    = 1'b0;
                    resolved_d[slot] = 1'b0;
                end
            end

            if (disp_ready_o) begin
                for (int k = 0; k < int'(WAYS); k++) begin
                    if (disp_valid_i[k]) begin
                        slot                = tail_q[PTR_W-1:0] + idx_t'(n_disp);
                        valid_d[slot]       = 1'b1;
                        resolved_d[slot]    = 1'b0;
                        tag_d[slot]         = disp_tag_i[k*TAG_W +: TAG_W];
                        pred_taken_d[slot]  = disp_pred_taken_i[k];
                        pred_target_d[slot] = disp_pred_target_i[k*XLEN +: XLEN];
                        n_disp              = n_disp + cnt_t'(1);
                    end
                end
            end

            head_d  = head_q + ptr_t'(n_ret);
            tail_d  = tail_q + ptr_t'(n_disp);
            count_d = count_q + n_disp - n_ret;
        end else begin
            valid_d    = '0;
            resolved_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end

        if (!reset) begin
            ret_mispred_o = '0;
            ret_target_o  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= '0;
            resolved_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Payload is qualified by valid/resolved, so it needs no reset.
    always_ff @(posedge clk) begin
        pred_taken_q  <= pred_taken_d;
        mispred_q     <= mispred_d;
        tag_q         <= tag_d;
        pred_target_q <= pred_target_d;
        target_q      <= target_d;
    end

    assign count_o   = count_q;
    assign ret_err_o = err_q;
    assign empty_o   = head_q == tail_q;
    assign full_o    = (head_q[PTR_W] != tail_q[PTR_W]) &&
                       (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);

endmodule

// File: tb/tb_branch_resolve_buffer.sv
// Scoreboard bench for branch_resolve_buffer: stimulus pushes expected retire and
// status values; a negedge monitor pops and compares them.
module tb_branch_resolve_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [1:0]  disp_valid;
    logic [11:0] disp_tag;
    logic [1:0]  disp_pred_taken;
    logic [63:0] disp_pred_target;
    logic        disp_ready;
    logic        res_valid;
    logic [5:0]  res_tag;
    logic        res_taken;
    logic [31:0] res_target;
    logic [31:0] res_pc;
    logic [1:0]  ret_en;
    logic [1:0]  ret_mispred;
    logic [63:0] ret_target;
    logic        ret_err;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    branch_resolve_buffer dut (
        .clk                (clk),
        .reset              (reset),
        .flush_i            (flush),
        .disp_valid_i       (disp_valid),
        .disp_tag_i         (disp_tag),
        .disp_pred_taken_i  (disp_pred_taken),
        .disp_pred_target_i (disp_pred_target),
        .disp_ready_o       (disp_ready),
        .res_valid_i        (res_valid),
        .res_tag_i          (res_tag),
        .res_taken_i        (res_taken),
        .res_target_i       (res_target),
        .res_pc_i           (res_pc),
        .ret_en_i           (ret_en),
        .ret_mispred_o      (ret_mispred),
        .ret_target_o       (ret_target),
        .ret_err_o          (ret_err),
        .count_o            (count),
        .full_o             (full),
        .empty_o            (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mispred;
        logic [63:0] target;
    } ret_exp_t;

    typedef struct {
        string name;
        int    count;   // negative: not checked
        bit    empty;
        bit    full;
        bit    ready;
        bit    err;
    } stat_exp_t;

    ret_exp_t  ret_q[$];
    stat_exp_t stat_q[$];
    ret_exp_t  re;
    stat_exp_t se;
    int        n_checks = 0;
    int        n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ret_en !== 2'b00) begin
            if (ret_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_retire: got ret_en 0x%0h, expected no retire", ret_en);
            end else begin
                re = ret_q.pop_front();
                check({re.name, "_mispred"}, 64'(ret_mispred), 64'(re.mispred));
                check({re.name, "_target"}, ret_target, re.target);
            end
        end
        while (stat_q.size() > 0) begin
            se = stat_q.pop_front();
            if (se.count >= 0) check({se.name, "_count"}, 64'(count), 64'(se.count));
            check({se.name, "_empty"}, 64'(empty), 64'(se.empty));
            check({se.name, "_full"}, 64'(full), 64'(se.full));
            check({se.name, "_ready"}, 64'(disp_ready), 64'(se.ready));
            check({se.name, "_err"}, 64'(ret_err), 64'(se.err));
        end
    end

    task automatic idle_inputs();
        flush            = 1'b0;
        disp_valid       = '0;
        disp_tag         = '0;
        disp_pred_taken  = '0;
        disp_pred_target = '0;
        res_valid        = 1'b0;
        res_tag          = '0;
        res_taken        = 1'b0;
        res_target       = '0;
        res_pc           = '0;
        ret_en           = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic set_disp(input logic [1:0] v, input int t0, input int t1, input bit pt,
                            input logic [31:0] ptgt);
        disp_valid       = v;
        disp_tag         = {6'(t1), 6'(t0)};
        disp_pred_taken  = {pt, pt};
        disp_pred_target = {ptgt, ptgt};
    endtask

    task automatic set_res(input int tag, input bit taken, input logic [31:0] tgt,
                           input logic [31:0] pc);
        res_valid  = 1'b1;
        res_tag    = 6'(tag);
        res_taken  = taken;
        res_target = tgt;
        res_pc     = pc;
    endtask

    task automatic exp_ret(input string name, input logic [1:0] en, input logic [1:0] mp,
                           input logic [31:0] t0, input logic [31:0] t1);
        ret_exp_t e;
        ret_en    = en;
        e.name    = name;
        e.mispred = mp;
        e.target  = {t1, t0};
        ret_q.push_back(e);
    endtask

    task automatic exp_stat(input string name, input int c, input bit em, input bit fu,
                            input bit rd, input bit er);
        stat_exp_t s;
        s.name  = name;
        s.count = c;
        s.empty = em;
        s.full  = fu;
        s.ready = rd;
        s.err   = er;
        stat_q.push_back(s);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        tick();
        // Held in reset: state cleared and retire outputs suppressed.
        exp_ret("reset_ret", 2'b01, 2'b00, 32'h0, 32'h0);
        exp_stat("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;

        // Two not-taken predictions, resolved out of order.
        set_disp(2'b11, 5, 6, 1'b0, 32'h0);
        exp_stat("t2_pre", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_res(6, 1'b1, 32'h100, 32'h1000);
        exp_stat("t2_two", 2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_res(5, 1'b0, 32'h0, 32'h2000);
        tick();
        exp_ret("t2_ret", 2'b11, 2'b10, 32'h0, 32'h100);
        tick();
        exp_stat("t2_post", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Predicted-taken cases: wrong target, not taken, correct target.
        set_disp(2'b11, 7, 8, 1'b1, 32'h200);
        tick();
        set_res(7, 1'b1, 32'h204, 32'h10);
        set_disp(2'b01, 10, 0, 1'b1, 32'h300);
        tick();
        set_res(8, 1'b0, 32'hdead, 32'h80);
        tick();
        set_res(10, 1'b1, 32'h300, 32'h30);
        tick();
        set_res(33, 1'b1, 32'h999, 32'h0);
        exp_ret("t3_ret", 2'b11, 2'b11, 32'h204, 32'h84);
        tick();
        exp_ret("t3_equal", 2'b01, 2'b00, 32'h0, 32'h0);
        tick();

        // Duplicate tags resolve oldest first.
        set_disp(2'b11, 12, 12, 1'b0, 32'h0);
        exp_stat("dup_pre", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_res(12, 1'b1, 32'h500, 32'h50);
        tick();
        set_res(12, 1'b0, 32'h0, 32'h60);
        tick();
        exp_ret("dup_ret", 2'b11, 2'b01, 32'h500, 32'h0);
        tick();
        exp_stat("dup_post", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Fill from head=7 so the tail wraps; resolve the four oldest along the way.
        for (int i = 0; i < 8; i++) begin
            set_disp(2'b11, 20 + 2 * i, 21 + 2 * i, 1'b0, 32'h0);
            if (i >= 1 && i <= 4) set_res(19 + i, 1'b0, 32'h0, 32'h0);
            if (i == 7) exp_stat("fill_14", 14, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        exp_stat("full", 16, 1'b0, 1'b1, 1'b0, 1'b0);
        set_disp(2'b11, 40, 41, 1'b0, 32'h0);
        exp_ret("full_ret", 2'b01, 2'b00, 32'h0, 32'h0);
        tick();
        exp_stat("cnt15", 15, 1'b0, 1'b0, 1'b0, 1'b0);
        set_disp(2'b11, 42, 43, 1'b0, 32'h0);
        exp_ret("cnt15_ret", 2'b01, 2'b00, 32'h0, 32'h0);
        tick();
        exp_stat("cnt14", 14, 1'b0, 1'b0, 1'b1, 1'b0);
        set_disp(2'b11, 44, 45, 1'b0, 32'h0);
        exp_ret("wrap_ret", 2'b11, 2'b00, 32'h0, 32'h0);
        tick();
        exp_stat("wrap_post", 14, 1'b0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        exp_stat("flush1", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Same-cycle resolve and retire of the head entry.
        set_disp(2'b01, 9, 0, 1'b0, 32'h0);
        tick();
        set_res(9, 1'b1, 32'h40, 32'h4);
        exp_ret("bypass", 2'b01, 2'b01, 32'h40, 32'h0);
        exp_stat("bypass_pre", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        exp_stat("bypass_post", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Flush with five entries plus concurrent dispatch and retire.
        set_disp(2'b11, 50, 51, 1'b0, 32'h0);
        tick();
        set_disp(2'b11, 52, 53, 1'b0, 32'h0);
        tick();
        set_disp(2'b01, 54, 0, 1'b0, 32'h0);
        tick();
        exp_stat("five", 5, 1'b0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        set_disp(2'b11, 55, 56, 1'b0, 32'h0);
        exp_ret("flush_ret", 2'b01, 2'b00, 32'h0, 32'h0);
        tick();
        exp_stat("flush2", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_ret("empty_ret", 2'b01, 2'b00, 32'h0, 32'h0);
        tick();
        exp_stat("err_set", -1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        exp_stat("err_sticky", -1, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        exp_stat("err_reset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        @(negedge clk);
        #1;
        check("ret_queue_drained", 64'(ret_q.size()), 64'd0);
        check("stat_queue_drained", 64'(stat_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
